seq_det_prog_moore: RTL and testbench
=====================================

// Module: seq_det_prog_moore
// PURPOSE
//  Runtime-programmable serial bit-sequence detector with a Moore-style output.
//  Patterns are 1..MAX_LEN bits long; detection is overlapping or non-overlapping, selected at runtime.
//  It has a qualifying valid strobe and a saturating match counter.
//  It is the generalised replacement for the fixed-pattern 110/101/1011 detectors.
//  It sits between a serial bit source and control/status logic.
// PARAMETERS
//  MAX_LEN  8   maximum pattern length in bits (>=2)
//  LEN_W    4   width of pat_len; must satisfy 2**LEN_W > MAX_LEN
//  CNT_W    16  width of the match counter
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        synchronous reset, active-high
//  in          in   1        serial data bit
//  in_valid    in   1        in is sampled only on edges where in_valid=1
//  cfg_load    in   1        latch pattern/pat_len/overlap_en; restart detection
//  pattern     in   MAX_LEN  pattern bits; first bit received = pattern[pat_len-1], last = pattern[0]
//  pat_len     in   LEN_W    pattern length; legal range is 1..MAX_LEN
//  overlap_en  in   1        1 = overlapping detection, 0 = non-overlapping
//  out         out  1        Moore detect flag (registered)
//  match_cnt   out  CNT_W    saturating count of detections
//  cfg_err     out  1        last loaded pat_len was illegal; detector disabled
// BEHAVIOUR
//  - Reset (rst=1 at an edge) clears all state, whatever else is asserted:
//    - registers: hist=0, fill=0, out=0, match_cnt=0, cfg_err=0
//    - config shadow: pat=0, len=1, ovl=1
//    - rst beats cfg_load and in_valid on the same edge.
//  - Config shadow:
//    - On cfg_load=1, capture pattern, pat_len and overlap_en.
//    - Also on cfg_load=1: clear hist and fill, set out=0; match_cnt is kept.
//    - If pat_len==0 or pat_len>MAX_LEN: set cfg_err=1, and out stays 0 until the next legal load.
//    - cfg_load has priority over in_valid on the same edge; that bit is dropped.
//    - Inputs are ignored between loads.
//  - Datapath on an edge with in_valid=1 and no rst/cfg_load:
//    - hist <= {hist[MAX_LEN-2:0], in}
//    - fill <= min(fill+1, MAX_LEN)
//    - hit = (fill+1 >= len) && ({hist,in}[len-1:0] == pat[len-1:0])
//    - The compare covers only the len LSBs; upper bits are masked.
//  - Moore output (equivalent to a terminal "match" state):
//    - out <= hit on each valid edge.
//    - out is high for the cycle(s) after the edge that samples the completing bit.
//    - out holds while in_valid=0, because the state is frozen; latency = 1 edge.
//  - Overlap modes:
//    - overlap_en=1: hist and fill are untouched by a hit, so the match suffix is reused (1101101 with 110 -> 2 hits; 1111 with 11 -> 3 hits).
//    - overlap_en=0: a hit forces fill <= 0, so the next match needs len fresh bits (1111 with 11 -> 2 hits).
//  - match_cnt:
//    - Increments by 1 on every hit.
//    - Saturates at 2**CNT_W-1; no wrap.
//    - Cleared only by rst.
//  - len=1: every valid bit equal to pat[0] is a hit; overlap mode is irrelevant.
//  - len=MAX_LEN: the full history is compared and fill saturates; no overflow.
//  - Reset mid-pattern: partial history is lost; the next match needs len new valid bits.
// TESTING
//  T1 len=3, pat=3'b110, ovl=1, stream 1,1,0,1,1,0,0 -> out high after the 3rd and 6th valid bits only; match_cnt=2.
//  T2 len=2, pat=2'b11, ovl=0 vs ovl=1, stream 1,1,1,1 -> cnt=2 (hits at bits 2,4) vs cnt=3 (hits at bits 2,3,4).
//  T3 pat 110, in_valid toggled 1,0,0,1,1 on bits 1,1,0 with junk while invalid -> single hit; out holds high through a following in_valid=0 gap.
//  T4 cfg_load with pat_len=0 -> cfg_err=1 and no hits on a matching stream.
//     Then load len=4, pat=4'b1011, stream 1011011 -> cfg_err=0, hits at bits 4 and 7.
//  T5 CNT_W=3 build, 10 hits -> match_cnt sticks at 7.
//     Assert rst mid-pattern (after 1,1 of 110), then send 0 -> no hit; all outputs 0 the cycle after rst.
//  T6 len=MAX_LEN=8, pat=8'hA5, stream of 16 bits A5A5 with ovl=1 -> exactly 2 hits.
//     cfg_load on the same edge as a completing bit -> no hit.

Source files
------------

// File: rtl/seq_det_prog_moore.sv
// Runtime-programmable serial pattern detector (1..MAX_LEN bits) with a Moore detect flag.
// One edge of latency from the completing valid bit to out; the state freezes while in_valid=0.
module seq_det_prog_moore #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap_en,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  typedef enum logic [1:0] {
    S_SCAN  = 2'd0,
    S_MATCH = 2'd1,
    S_DIS   = 2'd2
  } state_t;

  state_t             state;
  logic [MAX_LEN-2:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic               ovl;

  logic [MAX_LEN-1:0] win;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W:0]     fill_inc;
  logic               len_ok;
  logic               hit;

  // The window is the history as it will look after this bit is shifted in.
  always_comb begin
    win      = {hist, in};
    mask     = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len)) mask[i] = 1'b1;
    end
    fill_inc = {1'b0, fill} + {{LEN_W{1'b0}}, 1'b1};
    hit      = (state != S_DIS) &&
               (fill_inc >= {1'b0, len}) &&
               (((win ^ pat) & mask) == '0);
    len_ok   = (pat_len != '0) && (pat_len <= LEN_W'(MAX_LEN));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_SCAN;
      hist      <= '0;
      fill      <= '0;
      out       <= 1'b0;
      match_cnt <= '0;
      cfg_err   <= 1'b0;
      pat       <= '0;
      len       <= LEN_W'(1);
      ovl       <= 1'b1;
    end else if (cfg_load) begin
      pat     <= pattern;
      len     <= pat_len;
      ovl     <= overlap_en;
      hist    <= '0;
      fill    <= '0;
      out     <= 1'b0;
      cfg_err <= !len_ok;
      state   <= len_ok ? S_SCAN : S_DIS;
    end else if (in_valid && (state != S_DIS)) begin
      hist  <= win[MAX_LEN-2:0];
      out   <= hit;
      state <= hit ? S_MATCH : S_SCAN;
      // Non-overlapping mode discards the matched bits so the next hit needs len fresh bits.
      if (hit && !ovl) begin
        fill <= '0;
      end else if (fill != LEN_W'(MAX_LEN)) begin
        fill <= fill + LEN_W'(1);
      end
      if (hit && (match_cnt != '1)) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_det_prog_moore.sv
// Directed-vector bench for seq_det_prog_moore; a 16-bit and a 3-bit counter build share the stimulus.
module tb_seq_det_prog_moore;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in = 1'b0;
  logic        in_valid = 1'b0;
  logic        cfg_load = 1'b0;
  logic [7:0]  pattern = '0;
  logic [3:0]  pat_len = '0;
  logic        overlap_en = 1'b0;

  logic        out, cfg_err, out_s, cfg_err_s;
  logic [15:0] match_cnt;
  logic [2:0]  match_cnt_s;

  always #5 clk = ~clk;

  seq_det_prog_moore #(.MAX_LEN(8), .LEN_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .cfg_load(cfg_load),
    .pattern(pattern), .pat_len(pat_len), .overlap_en(overlap_en),
    .out(out), .match_cnt(match_cnt), .cfg_err(cfg_err)
  );

  seq_det_prog_moore #(.MAX_LEN(8), .LEN_W(4), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .cfg_load(cfg_load),
    .pattern(pattern), .pat_len(pat_len), .overlap_en(overlap_en),
    .out(out_s), .match_cnt(match_cnt_s), .cfg_err(cfg_err_s)
  );

  typedef struct {
    int    issue;
    logic  eo;
    int    ec;
    logic  ee;
    string nm;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input string what, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s %s got %0d want %0d", nm, what, got, want);
    end
  endtask

  // Monitor: every edge presents a fresh output sample; retire expectations issued before it.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].issue < cyc) begin
      e = sb.pop_front();
      chk(e.nm, "out",       {31'd0, out},        {31'd0, e.eo});
      chk(e.nm, "match_cnt", {16'd0, match_cnt},  e.ec);
      chk(e.nm, "cfg_err",   {31'd0, cfg_err},    {31'd0, e.ee});
      chk(e.nm, "out_s",     {31'd0, out_s},      {31'd0, e.eo});
      chk(e.nm, "cnt_s",     {29'd0, match_cnt_s}, (e.ec > 7) ? 7 : e.ec);
      chk(e.nm, "cfg_err_s", {31'd0, cfg_err_s},  {31'd0, e.ee});
    end
  end

  task automatic drv(input logic r, input logic cl, input logic v, input logic b,
                     input logic eo, input int ec, input logic ee, input string nm);
    exp_t x;
    @(negedge clk);
    rst      = r;
    cfg_load = cl;
    in_valid = v;
    in       = b;
    x.issue  = cyc;
    x.eo     = eo;
    x.ec     = ec;
    x.ee     = ee;
    x.nm     = nm;
    sb.push_back(x);
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
    pattern    = p;
    pat_len    = l;
    overlap_en = o;
  endtask

  initial begin
    // rst beats cfg_load/in_valid; defaults are len=1, pat=0, so a valid 0 is a hit
    cfg(8'hFF, 4'd3, 1'b0);
    drv(1, 1, 1, 0, 0, 0, 0, "rst_prio");
    drv(0, 0, 1, 0, 1, 1, 0, "dflt_b0");
    drv(0, 0, 1, 1, 0, 1, 0, "dflt_b1");
    drv(0, 0, 1, 0, 1, 2, 0, "dflt_b0b");

    // T1: 110 overlapping, stream 1101100
    cfg(8'b110, 4'd3, 1'b1);
    drv(0, 1, 0, 0, 0, 2, 0, "t1_load");
    drv(0, 0, 1, 1, 0, 2, 0, "t1_b1");
    drv(0, 0, 1, 1, 0, 2, 0, "t1_b2");
    drv(0, 0, 1, 0, 1, 3, 0, "t1_b3");
    drv(0, 0, 1, 1, 0, 3, 0, "t1_b4");
    drv(0, 0, 1, 1, 0, 3, 0, "t1_b5");
    drv(0, 0, 1, 0, 1, 4, 0, "t1_b6");
    drv(0, 0, 1, 0, 0, 4, 0, "t1_b7");

    // T2: 11 non-overlapping then overlapping, stream 1111
    cfg(8'b11, 4'd2, 1'b0);
    drv(0, 1, 0, 0, 0, 4, 0, "t2n_load");
    drv(0, 0, 1, 1, 0, 4, 0, "t2n_b1");
    drv(0, 0, 1, 1, 1, 5, 0, "t2n_b2");
    drv(0, 0, 1, 1, 0, 5, 0, "t2n_b3");
    drv(0, 0, 1, 1, 1, 6, 0, "t2n_b4");
    cfg(8'b11, 4'd2, 1'b1);
    drv(0, 1, 0, 0, 0, 6, 0, "t2o_load");
    drv(0, 0, 1, 1, 0, 6, 0, "t2o_b1");
    drv(0, 0, 1, 1, 1, 7, 0, "t2o_b2");
    drv(0, 0, 1, 1, 1, 8, 0, "t2o_b3");
    drv(0, 0, 1, 1, 1, 9, 0, "t2o_b4");

    // T3: gaps in in_valid carry junk; out holds across a gap
    cfg(8'b110, 4'd3, 1'b1);
    drv(0, 1, 0, 0, 0, 9, 0, "t3_load");
    drv(0, 0, 1, 1, 0, 9, 0, "t3_v1");
    drv(0, 0, 0, 0, 0, 9, 0, "t3_junk0");
    drv(0, 0, 0, 1, 0, 9, 0, "t3_junk1");
    drv(0, 0, 1, 1, 0, 9, 0, "t3_v2");
    drv(0, 0, 1, 0, 1, 10, 0, "t3_v3");
    drv(0, 0, 0, 0, 1, 10, 0, "t3_hold1");
    drv(0, 0, 0, 1, 1, 10, 0, "t3_hold2");
    drv(0, 0, 1, 0, 0, 10, 0, "t3_v4");

    // T4: illegal lengths disable the detector, then a legal 1011 load
    cfg(8'h00, 4'd0, 1'b1);
    drv(0, 1, 0, 0, 0, 10, 1, "t4_len0");
    drv(0, 0, 1, 0, 0, 10, 1, "t4_d0");
    drv(0, 0, 1, 1, 0, 10, 1, "t4_d1");
    drv(0, 0, 1, 0, 0, 10, 1, "t4_d2");
    cfg(8'h01, 4'd9, 1'b1);
    drv(0, 1, 0, 0, 0, 10, 1, "t4_len9");
    drv(0, 0, 1, 1, 0, 10, 1, "t4_d3");
    cfg(8'b1011, 4'd4, 1'b1);
    drv(0, 1, 0, 0, 0, 10, 0, "t4_load");
    drv(0, 0, 1, 1, 0, 10, 0, "t4_b1");
    drv(0, 0, 1, 0, 0, 10, 0, "t4_b2");
    drv(0, 0, 1, 1, 0, 10, 0, "t4_b3");
    drv(0, 0, 1, 1, 1, 11, 0, "t4_b4");
    drv(0, 0, 1, 0, 0, 11, 0, "t4_b5");
    drv(0, 0, 1, 1, 0, 11, 0, "t4_b6");
    drv(0, 0, 1, 1, 1, 12, 0, "t4_b7");

    // T5: the 3-bit counter has been pinned at 7; reset mid-pattern loses history
    cfg(8'b110, 4'd3, 1'b1);
    drv(0, 1, 0, 0, 0, 12, 0, "t5_load");
    drv(0, 0, 1, 1, 0, 12, 0, "t5_b1");
    drv(0, 0, 1, 1, 0, 12, 0, "t5_b2");
    drv(1, 0, 0, 0, 0, 0, 0, "t5_rst");
    drv(0, 1, 0, 0, 0, 0, 0, "t5_reload");
    drv(0, 0, 1, 0, 0, 0, 0, "t5_b0");
    drv(0, 0, 1, 1, 0, 0, 0, "t5_c1");
    drv(0, 0, 1, 1, 0, 0, 0, "t5_c2");
    drv(0, 0, 1, 0, 1, 1, 0, "t5_c3");

    // T6: full-length pattern A5 over A5A5, then cfg_load on a completing bit
    cfg(8'hA5, 4'd8, 1'b1);
    drv(0, 1, 0, 0, 0, 1, 0, "t6_load");
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 7; i >= 0; i--) begin
        drv(0, 0, 1, pattern[i], (i == 0), (i == 0) ? 2 + rep : 1 + rep, 0, "t6_bit");
      end
    end
    for (int i = 7; i >= 1; i--) begin
      drv(0, 0, 1, pattern[i], 0, 3, 0, "t6_pre");
    end
    drv(0, 1, 1, 1, 0, 3, 0, "t6_load_hit");
    drv(0, 0, 1, 1, 0, 3, 0, "t6_after");

    drv(0, 0, 0, 0, 0, 3, 0, "idle");
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
